// File: rtl/tri_median_engine.sv
// Doubled triangle median lengths via squared-norm + restoring bit-serial square root.
// Optional MEDIAN_SQ_OUT_EN adds sa/sb/sc ports carrying the squared doubled medians.
module tri_median_engine #(
   parameter int W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [W-1:0] ax,
   input  logic signed [W-1:0] ay,
   input  logic signed [W-1:0] bx,
   input  logic signed [W-1:0] by,
   input  logic signed [W-1:0] cx,
   input  logic signed [W-1:0] cy,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [W+2:0]        ma2,
   output logic [W+2:0]        mb2,
   output logic [W+2:0]        mc2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy
`ifdef MEDIAN_SQ_OUT_EN
   ,
   output logic [2*W+4:0]      sa,
   output logic [2*W+4:0]      sb,
   output logic [2*W+4:0]      sc
`endif
);

   localparam int N    = W + 3;
   localparam int SW   = 2 * W + 5;
   localparam int RW   = N + 4;
   localparam int CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, SQUARE, SQRT, DONE} state_t;

   state_t state, state_nxt;

   logic [1:0]          k;
   logic signed [W-1:0] ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
   logic [2*N-1:0]      rad;
   logic [RW-1:0]       rem;
   logic [N-1:0]        root;
   logic [CW-1:0]       cnt;

   logic signed [W-1:0] kx, ky, px, py, qx, qy;
   logic signed [W+1:0] dx, dy;
   logic signed [SW-1:0] dxe, dye;
   logic [SW-1:0]       s_cur;
   logic [RW-1:0]       rem_sh, trial, rem_nxt;
   logic [N-1:0]        root_nxt;

   // Vertex k against its two opposite vertices p and q
   always_comb begin
      kx = ax_r; ky = ay_r;
      px = bx_r; py = by_r;
      qx = cx_r; qy = cy_r;
      case (k)
         2'd1: begin
            kx = bx_r; ky = by_r;
            px = ax_r; py = ay_r;
            qx = cx_r; qy = cy_r;
         end
         2'd2: begin
            kx = cx_r; ky = cy_r;
            px = ax_r; py = ay_r;
            qx = bx_r; qy = by_r;
         end
         default: ;
      endcase
   end

   // W+2 bits always hold 2k-p-q exactly, so wrapping subtraction is safe
   assign dx    = {kx[W-1], kx, 1'b0} - {{2{px[W-1]}}, px} - {{2{qx[W-1]}}, qx};
   assign dy    = {ky[W-1], ky, 1'b0} - {{2{py[W-1]}}, py} - {{2{qy[W-1]}}, qy};
   assign dxe   = {{(SW-W-2){dx[W+1]}}, dx};
   assign dye   = {{(SW-W-2){dy[W+1]}}, dy};
   assign s_cur = SW'(dxe * dxe + dye * dye);

   assign rem_sh = {rem[RW-3:0], rad[2*N-1 -: 2]};
   assign trial  = {{(RW-N-2){1'b0}}, root, 2'b01};

   always_comb begin
      rem_nxt  = rem_sh;
      root_nxt = {root[N-2:0], 1'b0};
      if (rem_sh >= trial) begin
         rem_nxt  = rem_sh - trial;
         root_nxt = {root[N-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (in_valid) state_nxt = SQUARE;
         SQUARE: state_nxt = SQRT;
         SQRT:   if (cnt == LAST) state_nxt = (k == 2'd2) ? DONE : SQUARE;
         DONE:   if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k    <= 2'd0;
         ax_r <= '0; ay_r <= '0;
         bx_r <= '0; by_r <= '0;
         cx_r <= '0; cy_r <= '0;
         rad  <= '0;
         rem  <= '0;
         root <= '0;
         cnt  <= '0;
         ma2  <= '0;
         mb2  <= '0;
         mc2  <= '0;
`ifdef MEDIAN_SQ_OUT_EN
         sa   <= '0;
         sb   <= '0;
         sc   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  k    <= 2'd0;
                  ax_r <= ax; ay_r <= ay;
                  bx_r <= bx; by_r <= by;
                  cx_r <= cx; cy_r <= cy;
               end
            end
            SQUARE: begin
               rad  <= {1'b0, s_cur};
               rem  <= '0;
               root <= '0;
               cnt  <= '0;
`ifdef MEDIAN_SQ_OUT_EN
               case (k)
                  2'd0:    sa <= s_cur;
                  2'd1:    sb <= s_cur;
                  default: sc <= s_cur;
               endcase
`endif
            end
            SQRT: begin
               rad  <= {rad[2*N-3:0], 2'b00};
               rem  <= rem_nxt;
               root <= root_nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  case (k)
                     2'd0:    ma2 <= root_nxt;
                     2'd1:    mb2 <= root_nxt;
                     default: mc2 <= root_nxt;
                  endcase
                  if (k != 2'd2) k <= k + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_median_engine.sv
// Randomized and directed bench for tri_median_engine against an arithmetic median model.
// Honours MEDIAN_SQ_OUT_EN when the design is built with it.
module tb_tri_median_engine;

   localparam int W   = 8;
   localparam int LAT = 3 * (W + 4);

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic signed [W-1:0] ax, ay, bx, by, cx, cy;
   logic                in_valid, in_ready;
   logic [W+2:0]        ma2, mb2, mc2;
   logic                out_valid, out_ready, busy;
`ifdef MEDIAN_SQ_OUT_EN
   logic [2*W+4:0]      sa, sb, sc;
`endif

   int     checks = 0;
   int     failures = 0;
   longint expM[3];
   longint expS[3];
   longint lastM[3];
   longint lastS[3];

   always #5 clk = ~clk;

   tri_median_engine #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
      .in_valid(in_valid), .in_ready(in_ready),
      .ma2(ma2), .mb2(mb2), .mc2(mc2),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
`ifdef MEDIAN_SQ_OUT_EN
      , .sa(sa), .sb(sb), .sc(sc)
`endif
   );

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Median from vertex i is half of |2*Vi - Vp - Vq|; output is floor of the doubled length
   function automatic void computeExpected(input int vax, input int vay, input int vbx,
                                           input int vby, input int vcx, input int vcy);
      int xs[3];
      int ys[3];
      xs[0] = vax; xs[1] = vbx; xs[2] = vcx;
      ys[0] = vay; ys[1] = vby; ys[2] = vcy;
      for (int i = 0; i < 3; i++) begin
         longint dx, dy, s, r;
         int p, q;
         p = (i == 0) ? 1 : 0;
         q = (i == 2) ? 1 : 2;
         dx = 2 * xs[i] - xs[p] - xs[q];
         dy = 2 * ys[i] - ys[p] - ys[q];
         s = dx * dx + dy * dy;
         r = 0;
         while ((r + 1) * (r + 1) <= s) r++;
         expS[i] = s;
         expM[i] = r;
      end
   endfunction

   task automatic setInputs(input int vax, input int vay, input int vbx,
                            input int vby, input int vcx, input int vcy);
      ax = vax[W-1:0]; ay = vay[W-1:0];
      bx = vbx[W-1:0]; by = vby[W-1:0];
      cx = vcx[W-1:0]; cy = vcy[W-1:0];
   endtask

   task automatic checkResults(input string tag);
      checkOutput({tag, "_ma2"}, longint'(ma2), expM[0]);
      checkOutput({tag, "_mb2"}, longint'(mb2), expM[1]);
      checkOutput({tag, "_mc2"}, longint'(mc2), expM[2]);
`ifdef MEDIAN_SQ_OUT_EN
      checkOutput({tag, "_sa"}, longint'(sa), expS[0]);
      checkOutput({tag, "_sb"}, longint'(sb), expS[1]);
      checkOutput({tag, "_sc"}, longint'(sc), expS[2]);
`endif
   endtask

   task automatic waitOutValid(input string tag);
      int lat = 0;
      while (!out_valid && lat < LAT + 50) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, LAT);
   endtask

   // One full transaction; caller must be away from the clock edge with the DUT idle
   task automatic applyStimulus(input string tag, input int vax, input int vay, input int vbx,
                                input int vby, input int vcx, input int vcy,
                                input int stall, input bit poke);
      computeExpected(vax, vay, vbx, vby, vcx, vcy);
      setInputs(vax, vay, vbx, vby, vcx, vcy);
      in_valid = 1'b1;
      checkOutput({tag, "_in_ready_idle"}, longint'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput({tag, "_busy"}, longint'(busy), 1);
      waitOutValid(tag);
      checkResults(tag);
      for (int i = 0; i < stall; i++) begin
         if (poke) begin
            in_valid = 1'($urandom_range(1));
            setInputs(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                      int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                      int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
         end
         @(posedge clk); #1;
         checkOutput({tag, "_stall_out_valid"}, longint'(out_valid), 1);
         checkOutput({tag, "_stall_in_ready"}, longint'(in_ready), 0);
         checkResults({tag, "_stall"});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({tag, "_out_valid_drop"}, longint'(out_valid), 0);
      checkOutput({tag, "_in_ready_back"}, longint'(in_ready), 1);
      lastM = expM;
      lastS = expS;
   endtask

   initial begin
      longint m1[3];
      in_valid  = 1'b0;
      out_ready = 1'b0;
      setInputs(0, 0, 0, 0, 0, 0);
      #23;
      checkOutput("reset_out_valid", longint'(out_valid), 0);
      checkOutput("reset_busy", longint'(busy), 0);
      checkOutput("reset_ma2", longint'(ma2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_in_ready", longint'(in_ready), 1);

      // First accept on the first edge after release
      applyStimulus("req027", 1, -1, -4, 6, -3, -5, 0, 1'b0);
      checkOutput("req027_const_ma2", lastM[0], 9);
      checkOutput("req027_const_mb2", lastM[1], 18);
      checkOutput("req027_const_mc2", lastM[2], 15);

      applyStimulus("req028", -128, -128, 127, 127, 127, 127, 2, 1'b0);
      checkOutput("req028_const_ma2", lastM[0], 721);
      checkOutput("req028_const_mb2", lastM[1], 360);
      checkOutput("req028_const_sa", lastS[0], 520200);

      applyStimulus("degenerate", 5, 5, 5, 5, 5, 5, 0, 1'b0);
      checkOutput("degenerate_const_ma2", lastM[0], 0);

      // Back-pressure while new data is pulsed at the input
      applyStimulus("stall", 100, -50, -77, 3, 12, 120, 20, 1'b1);

      // Reset in the middle of an operation
      setInputs(30, 40, -20, 10, 7, -90);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", longint'(out_valid), 0);
      checkOutput("midreset_busy", longint'(busy), 0);
      checkOutput("midreset_ma2", longint'(ma2), 0);
      checkOutput("midreset_mb2", longint'(mb2), 0);
      checkOutput("midreset_mc2", longint'(mc2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midreset_in_ready", longint'(in_ready), 1);
      applyStimulus("after_reset", -60, 33, 71, -14, 2, 99, 1, 1'b0);

      // Back-to-back with in_valid held high and out_ready held high
      computeExpected(11, -22, 33, 44, -55, 66);
      m1 = expM;
      setInputs(11, -22, 33, 44, -55, 66);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      setInputs(-99, 88, 77, -66, 55, -44);
      checkOutput("b2b_first_busy", longint'(busy), 1);
      waitOutValid("b2b_first");
      computeExpected(11, -22, 33, 44, -55, 66);
      checkResults("b2b_first");
      @(posedge clk); #1;
      checkOutput("b2b_handshake_in_ready", longint'(in_ready), 1);
      checkOutput("b2b_handshake_out_valid", longint'(out_valid), 0);
      @(posedge clk); #1;
      checkOutput("b2b_second_accept", longint'(busy), 1);
      in_valid = 1'b0;
      waitOutValid("b2b_second");
      computeExpected(-99, 88, 77, -66, 55, -44);
      checkResults("b2b_second");
      checkOutput("b2b_differs", longint'(expM[0] != m1[0]), 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("b2b_idle", longint'(in_ready), 1);

      for (int t = 0; t < 20; t++) begin
         applyStimulus($sformatf("rand%0d", t),
                       int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                       int'($urandom_range(3)), 1'($urandom_range(1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/tri_median_engine.md
TRI_MEDIAN_ENGINE -- requirements
Module: tri_median_engine

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the signed two's-complement width of each vertex coordinate (legal range 4..16).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the ports ax, ay, bx, by, cx, cy, input, W bits signed each: triangle vertices A, B and C.
REQ-005 The block SHALL have the port in_valid, input, 1 bit, and the port in_ready, output, 1 bit: the input handshake.
REQ-006 The block SHALL have the ports ma2, mb2, mc2, output, W+3 bits unsigned each: twice the median length from A, B and C respectively, floored.
REQ-007 The block SHALL have the port out_valid, output, 1 bit, and the port out_ready, input, 1 bit: the output handshake.
REQ-008 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 The block SHALL capture all six coordinates into internal registers on a clock edge where in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-010 For vertex k with opposite vertices p and q, the block SHALL form the doubled median vector dk = 2k - p - q, per axis, in W+2-bit signed arithmetic with no overflow.
REQ-011 The block SHALL form Sk = dkx^2 + dky^2 in 2W+5-bit unsigned arithmetic, exactly equal to 4*median_k^2.
REQ-012 The block SHALL produce the output for vertex k as floor(sqrt(Sk)), computed by a restoring bit-serial square root that resolves one result bit per cycle, MSB first, over W+3 cycles.
REQ-013 The FSM SHALL have exactly the states IDLE, SQUARE, SQRT and DONE.
REQ-014 IDLE -> SQUARE on accept; SQUARE (1 cycle, computes Sk for the current k) -> SQRT; SQRT (W+3 cycles) -> SQUARE while k < 2 with k incremented, else -> DONE.
REQ-015 Medians SHALL be processed in the order A, B, C, and each result register SHALL be written at the end of its SQRT phase.
REQ-016 Latency SHALL be 3*(W+4) cycles from the accept edge to out_valid rising (36 cycles for W=8).
REQ-017 In DONE, out_valid SHALL be 1 and ma2, mb2 and mc2 SHALL hold stable until out_ready is sampled 1; the FSM then returns to IDLE, out_valid drops and in_ready rises on the following cycle.
REQ-018 The block SHALL ignore in_valid asserted while busy; no input is captured and no state is disturbed.
REQ-019 Back-pressure (out_ready held 0) SHALL stall in DONE indefinitely without corrupting the outputs.
REQ-020 A degenerate triangle (all vertices coincident) SHALL produce 0 on all three outputs with normal latency.
REQ-021 The outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Reset
REQ-022 When rst_n is low, the block SHALL asynchronously force the FSM to IDLE, k to 0, ma2/mb2/mc2 to 0, out_valid to 0 and busy to 0; in_ready SHALL be 1 once reset is released.
REQ-023 An assertion of rst_n mid-computation SHALL abort the operation; no partial result SHALL ever appear with out_valid = 1.
REQ-024 After release, the first accept SHALL be possible on the first rising clk edge at which rst_n is high.

Configuration
REQ-025 With the macro MEDIAN_SQ_OUT_EN defined, the block SHALL add output ports sa, sb and sc (2W+5 bits unsigned each), carrying Sk and registered and held under the same out_valid rules as ma2/mb2/mc2, reset to 0.
REQ-026 Without MEDIAN_SQ_OUT_EN, the ports sa, sb and sc and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 With W=8, A=(1,-1), B=(-4,6), C=(-3,-5) and out_ready=1 -> out_valid SHALL rise 36 cycles after accept with ma2=9, mb2=18, mc2=15 (sa=90, sb=360, sc=234 if enabled).
REQ-028 With W=8, A=(-128,-128), B=C=(127,127) -> ma2=721, mb2=360, mc2=360 (sa=520200, sb=sc=130050).
REQ-029 With all vertices at (5,5) -> ma2=mb2=mc2=0 with normal latency.
REQ-030 Holding out_ready=0 for 20 cycles in DONE while pulsing in_valid with new data -> outputs stable, in_ready=0, no capture; then out_ready=1 -> IDLE on the next cycle.
REQ-031 Driving rst_n low at cycle 15 of an operation -> out_valid=0, outputs=0 and in_ready=1 after release; a fresh transaction then completes correctly.
REQ-032 Back-to-back transactions with in_valid held high -> the second accept SHALL occur exactly one cycle after the first out_valid && out_ready handshake, with correct results for both.
